// File: rtl/tick_prescaler_ctrl.sv
// tick_prescaler_ctrl: power-up sequencer plus programmable clock prescaler whose
// divisor updates arrive over a req/ack handshake and take effect on period boundaries.
module tick_prescaler_ctrl #(
    parameter int CNT_W          = 8,
    parameter int STARTUP_CYCLES = 128,
    parameter int DEFAULT_DIV    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_req,
    output logic             div_ack,
    output logic             busy,
    output logic             clk_presc,
    output logic             tick,
    output logic             reset_out,
    output logic [1:0]       state_dbg
);
    localparam int RST_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        STARTUP = 2'd1,
        ACTIVE  = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] div_pending_q, div_pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic             clk_presc_q, clk_presc_d;
    logic             tick_q, tick_d;
    logic             div_ack_q, div_ack_d;
    logic             reset_out_q, reset_out_d;
    logic             terminal, capture, apply;

    assign terminal = cnt_q == div_active_q;
    assign capture  = div_req && !pending_valid_q && !div_ack_q;
    // While running, a new divisor waits for the period end; otherwise it lands at once.
    assign apply    = pending_valid_q && (state_q == ACTIVE ? (run_en && terminal) : 1'b1);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rst_cnt_d       = rst_cnt_q;
        div_active_d    = div_active_q;
        div_pending_d   = div_pending_q;
        pending_valid_d = pending_valid_q;
        clk_presc_d     = clk_presc_q;
        tick_d          = 1'b0;
        div_ack_d       = 1'b0;
        reset_out_d     = reset_out_q;
        case (state_q)
            INIT: begin
                state_d   = STARTUP;
                cnt_d     = '0;
                rst_cnt_d = '0;
            end
            STARTUP: begin
                rst_cnt_d   = rst_cnt_q + 1'b1;
                cnt_d       = terminal ? '0 : cnt_q + 1'b1;
                clk_presc_d = clk_presc_q ^ terminal;
                if (rst_cnt_q == RST_LAST) begin
                    state_d     = ACTIVE;
                    reset_out_d = 1'b1;
                    rst_cnt_d   = '0;
                end
            end
            ACTIVE: begin
                state_d     = run_en ? ACTIVE : HALT;
                cnt_d       = !run_en ? '0 : terminal ? '0 : cnt_q + 1'b1;
                clk_presc_d = clk_presc_q ^ (run_en && terminal);
                tick_d      = run_en && terminal;
            end
            HALT: begin
                state_d = run_en ? ACTIVE : HALT;
                cnt_d   = '0;
            end
        endcase
        if (apply) begin
            div_active_d    = div_pending_q;
            pending_valid_d = 1'b0;
            cnt_d           = '0;
        end
        if (capture) begin
            div_pending_d   = div_val;
            pending_valid_d = 1'b1;
            div_ack_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= INIT;
            cnt_q           <= '0;
            rst_cnt_q       <= '0;
            div_active_q    <= DIV_RST;
            div_pending_q   <= '0;
            pending_valid_q <= 1'b0;
            clk_presc_q     <= 1'b0;
            tick_q          <= 1'b0;
            div_ack_q       <= 1'b0;
            reset_out_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rst_cnt_q       <= rst_cnt_d;
            div_active_q    <= div_active_d;
            div_pending_q   <= div_pending_d;
            pending_valid_q <= pending_valid_d;
            clk_presc_q     <= clk_presc_d;
            tick_q          <= tick_d;
            div_ack_q       <= div_ack_d;
            reset_out_q     <= reset_out_d;
        end
    end

    assign div_ack   = div_ack_q;
    assign busy      = pending_valid_q;
    assign clk_presc = clk_presc_q;
    assign tick      = tick_q;
    assign reset_out = reset_out_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_tick_prescaler_ctrl.sv
// tb_tick_prescaler_ctrl: directed scenarios for the prescaler controller; observed
// tuple is {state_dbg, reset_out, clk_presc, tick, busy, div_ack}.
module tb_tick_prescaler_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run_en = 1'b1;
    logic [7:0] div_val = 8'd0;
    logic       div_req = 1'b0;
    logic       div_ack, busy, clk_presc, tick, reset_out;
    logic [1:0] state_dbg;
    int         vectors = 0;
    int         miscompares = 0;
    logic       ec = 1'b0;

    tick_prescaler_ctrl dut (
        .clk(clk), .reset(reset), .run_en(run_en), .div_val(div_val), .div_req(div_req),
        .div_ack(div_ack), .busy(busy), .clk_presc(clk_presc), .tick(tick),
        .reset_out(reset_out), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] obs();
        return {state_dbg, reset_out, clk_presc, tick, busy, div_ack};
    endfunction

    task automatic check_startup(input int n);
        logic [6:0] exp;
        for (int e = 1; e <= n; e++) begin
            step();
            ec  = (e == 1) ? 1'b0 : (e % 2 == 0);
            exp = {(e >= 129) ? 2'd2 : 2'd1, e >= 129, ec, e >= 130, 1'b0, 1'b0};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL startup edge=%0d got=%b exp=%b", e, obs(), exp);
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (obs() !== 7'b0) begin
                miscompares++;
                $display("FAIL reset_hold got=%b exp=%b", obs(), 7'b0);
            end
        end
        reset = 1'b1;
        check_startup(135);
    endtask

    task automatic test_div3;
        logic [6:0] exp;
        logic t;
        div_val = 8'd3;
        div_req = 1'b1;
        for (int s = 1; s <= 14; s++) begin
            step();
            t   = (s == 1) || (s >= 2 && (s - 2) % 4 == 0);
            ec  = ec ^ t;
            exp = {2'd2, 1'b1, ec, t, s == 1, s == 1};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL div3 step=%0d got=%b exp=%b", s, obs(), exp);
            end
            if (s == 1) div_req = 1'b0;
        end
    endtask

    task automatic test_div9_aligned;
        logic [6:0] exp;
        logic t;
        for (int j = 1; j <= 30; j++) begin
            step();
            t   = (j == 4) || (j == 8) || (j == 18) || (j == 28);
            ec  = ec ^ t;
            exp = {2'd2, 1'b1, ec, t, j >= 4 && j <= 7, j == 4};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL div9_aligned step=%0d got=%b exp=%b", j, obs(), exp);
            end
            if (j == 3) begin
                div_val = 8'd9;
                div_req = 1'b1;
            end
            if (j == 4) div_req = 1'b0;
        end
    endtask

    task automatic test_halt;
        logic [6:0] exp;
        logic t;
        div_val = 8'd4;
        div_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            t   = (k == 8) || (k == 13) || (k == 18);
            ec  = ec ^ t;
            exp = {2'd2, 1'b1, ec, t, k <= 7, k == 1};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL div4_load step=%0d got=%b exp=%b", k, obs(), exp);
            end
            if (k == 1) div_req = 1'b0;
        end
        run_en = 1'b0;
        for (int h = 1; h <= 6; h++) begin
            step();
            exp = {2'd3, 1'b1, ec, 1'b0, h == 3, h == 3};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL halt step=%0d got=%b exp=%b", h, obs(), exp);
            end
            if (h == 2) div_req = 1'b1;
            if (h == 3) div_req = 1'b0;
        end
        run_en = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            step();
            t   = (i == 5);
            ec  = ec ^ t;
            exp = {2'd2, 1'b1, ec, t, 1'b0, 1'b0};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL resume step=%0d got=%b exp=%b", i, obs(), exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp;
        logic t, a;
        div_val = 8'd5;
        div_req = 1'b1;
        for (int b = 1; b <= 20; b++) begin
            step();
            t   = (b == 5) || (b == 11) || (b == 17);
            a   = (b == 1) || (b == 6) || (b == 12) || (b == 18);
            ec  = ec ^ t;
            exp = {2'd2, 1'b1, ec, t, !t, a};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL back_to_back step=%0d got=%b exp=%b", b, obs(), exp);
            end
        end
        div_req = 1'b0;
    endtask

    task automatic test_reset_midop;
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (obs() !== 7'b0) begin
            miscompares++;
            $display("FAIL async_reset_active got=%b exp=%b", obs(), 7'b0);
        end
        step();
        step();
        reset = 1'b1;
        check_startup(61);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (obs() !== 7'b0) begin
            miscompares++;
            $display("FAIL async_reset_startup got=%b exp=%b", obs(), 7'b0);
        end
        step();
        reset = 1'b1;
        check_startup(135);
    endtask

    initial begin
        test_reset();
        test_div3();
        test_div9_aligned();
        test_halt();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
